// File: rtl/wb_pkg.sv
// Shared writeback-stage types: result-select codes, FSM states, load funct3 encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  // Result source selected by MEM for the writeback value
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // Stage occupancy: idle, waiting on a late load response, or presenting a result
  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  // Load funct3 encodings; anything else is handled as a word load
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Extracts and sign/zero-extends the addressed byte/halfword/word from an aligned memory word.
// Latency: combinational.
// Backpressure: none; the enclosing stage decides when the result is used.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [XLEN-1:0]  data_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [2:0]       funct3_i,
  output logic [XLEN-1:0]  value_o,
  output logic             misalign_o
);

  logic [OFF_W+2:0] shamt;
  logic [31:0]      word;

  // Move the addressed byte lane down to bit 0; only the low word is ever needed
  assign shamt = {offset_i, 3'b000};
  assign word  = 32'(data_i >> shamt);

  // Pick the access width and extension; odd halfword offsets are flagged
  always_comb begin
    value_o    = XLEN'(signed'(word));
    misalign_o = 1'b0;
    case (funct3_i)
      LD_LB:  value_o = XLEN'(signed'(word[7:0]));
      LD_LBU: value_o = XLEN'(word[7:0]);
      LD_LH: begin
        value_o    = XLEN'(signed'(word[15:0]));
        misalign_o = offset_i[0];
      end
      LD_LHU: begin
        value_o    = XLEN'(word[15:0]);
        misalign_o = offset_i[0];
      end
      LD_LW:   value_o = XLEN'(signed'(word));
      default: value_o = XLEN'(signed'(word));
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects ALU/MEM/PC+4/IMM result, waits for late loads, drives RF write + forwarding tap.
// Latency: non-load result on rf_* one cycle after accept; load result one cycle after mem_rsp_valid.
// Backpressure: in_ready low while waiting on a load response or when flush is asserted.
// Optional retire counter port and logic enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
`ifdef WB_RETIRE_CNT_EN
  , parameter int CNT_W    = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_wb_sel,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [2:0]            in_ld_funct3,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  fwd_valid,
  output logic                  misalign
`ifdef WB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0]    retire_cnt
`endif
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  wb_state_e             state_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  rw_q;
  logic [2:0]            f3_q;
  logic [OFF_W-1:0]      off_q;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_q;
  logic                  misalign_q;

  logic                  accept;
  logic [XLEN-1:0]       nonld_res;
  logic [XLEN-1:0]       ld_val;
  logic                  ld_mis;

  assign in_ready = (state_q != ST_WAIT_MEM) && !flush;
  assign accept   = in_valid && in_ready;

  // Load data comes straight from the response bus using the offset/type captured at accept
  wb_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .data_i     (mem_rsp_data),
    .offset_i   (off_q),
    .funct3_i   (f3_q),
    .value_o    (ld_val),
    .misalign_o (ld_mis)
  );

  // Result mux for every source that is ready at accept time
  always_comb begin
    nonld_res = in_alu_result;
    case (wb_sel_e'(in_wb_sel))
      WB_PC4:  nonld_res = in_pc + XLEN'(4);
      WB_IMM:  nonld_res = in_imm;
      default: nonld_res = in_alu_result;
    endcase
  end

  // Stage FSM with registered RF/forwarding outputs; rf_* are cleared every cycle not entering WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_WAIT_MEM: begin
          // flush takes priority over a same-cycle response
          if (flush) begin
            state_q <= ST_EMPTY;
          end else if (mem_rsp_valid) begin
            state_q    <= ST_WRITE;
            rf_waddr_q <= rd_q;
            if (ld_mis) begin
              misalign_q <= 1'b1;
            end else begin
              rf_we_q    <= rw_q && (rd_q != '0);
              rf_wdata_q <= ld_val;
            end
          end
        end
        default: begin
          if (accept) begin
            rd_q  <= in_rd;
            rw_q  <= in_reg_write;
            f3_q  <= in_ld_funct3;
            off_q <= in_alu_result[OFF_W-1:0];
            if (in_wb_sel == WB_MEM) begin
              state_q <= ST_WAIT_MEM;
            end else begin
              state_q    <= ST_WRITE;
              rf_we_q    <= in_reg_write && (in_rd != '0);
              rf_waddr_q <= in_rd;
              rf_wdata_q <= nonld_res;
            end
          end else begin
            state_q <= ST_EMPTY;
          end
        end
      endcase
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign fwd_valid = rf_we_q;
  assign misalign  = misalign_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count every cycle spent in WRITE, suppressed and misaligned writes included
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_WRITE) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt = cnt_q;
`endif

endmodule
